// File: rtl/mul_err_monitor.sv
// Error-statistics collector for an 8x8 approximate multiplier under test.
// Recomputes A*B exactly and accumulates count, error count, distance sum and max over one run.
module mul_err_monitor #(
  parameter int NUM_SAMPLES = 1024,
  parameter int CNT_W       = 24,
  parameter int SUM_W       = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  input  logic [15:0]      O,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [SUM_W-1:0] ed_sum,
  output logic [15:0]      ed_max,
  output logic             sum_sat
);

  localparam int STAGES = 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] o;
  } smp_t;

  state_t           state;
  logic             drain_cnt;
  logic [CNT_W-1:0] acc_cnt;
  logic [STAGES:1]  vld_pipe;
  smp_t             s1;
  logic [15:0]      s2_ed;
  logic             s2_err;

  logic             accept, clr, last;
  logic [15:0]      prod, ed;
  logic [SUM_W:0]   sum_nxt;

  assign accept  = in_valid & in_ready;
  assign clr     = start & ((state == IDLE) | (state == DONE));
  assign last    = (acc_cnt == CNT_W'(NUM_SAMPLES - 1));
  assign prod    = 16'(s1.a) * 16'(s1.b);
  assign ed      = (prod >= s1.o) ? (prod - s1.o) : (s1.o - prod);
  // one spare MSB catches the carry out of the accumulator for saturation
  assign sum_nxt = {1'b0, ed_sum} + {{(SUM_W-15){1'b0}}, s2_ed};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state    <= RUN;
          in_ready <= 1'b1;
          busy     <= 1'b1;
          done     <= 1'b0;
        end
        RUN: if (accept && last) begin
          state     <= DRAIN;
          in_ready  <= 1'b0;
          drain_cnt <= 1'b0;
        end
        DRAIN: begin
          // two cycles lets the last accepted sample reach the accumulators
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt  <= '0;
      vld_pipe <= '0;
      s1       <= '0;
      s2_ed    <= '0;
      s2_err   <= 1'b0;
    end else begin
      if (clr)         acc_cnt <= '0;
      else if (accept) acc_cnt <= acc_cnt + CNT_W'(1);
      if (clr) vld_pipe <= '0;
      else     vld_pipe <= {vld_pipe[STAGES-1:1], accept};
      if (accept) s1 <= '{a: A, b: B, o: O};
      s2_ed  <= ed;
      s2_err <= (ed != 16'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      ed_sum     <= '0;
      ed_max     <= '0;
      sum_sat    <= 1'b0;
    end else if (clr) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      ed_sum     <= '0;
      ed_max     <= '0;
      sum_sat    <= 1'b0;
    end else if (vld_pipe[STAGES]) begin
      sample_cnt <= sample_cnt + CNT_W'(1);
      err_cnt    <= err_cnt + CNT_W'(s2_err);
      if (s2_ed > ed_max) ed_max <= s2_ed;
      if (sum_nxt[SUM_W]) begin
        ed_sum  <= '1;
        sum_sat <= 1'b1;
      end else begin
        ed_sum <= sum_nxt[SUM_W-1:0];
      end
    end
  end

endmodule
